conv_bram_pingpong: RTL and testbench
=====================================

# conv_bram_pingpong

Multi-bank circular BRAM buffer between the convolution data loader and the conv compute array. A writer fills one bank while the compute side reads a previously completed bank. Banks are handed between the two sides with explicit done/ready handshakes. This generalises the single-port conv BRAM to N banks, independent read and write ports, a read-valid pipeline and error flags.

## Interface
- RAM_WIDTH, 64, data word width in bits (multiple of 8)
- RAM_DEPTH, 512, words per bank
- NUM_BANKS, 2, bank count, legal range 2..8
- RAM_PERFORMANCE, "LOW_LATENCY", "LOW_LATENCY" (1-cycle read) or "HIGH_PERFORMANCE" (2-cycle read, output register)
- clka  in  1  clock; all logic on rising edge
- rsta  in  1  reset, asynchronous, active-low
- wr_en  in  1  write strobe into current write bank
- wr_addr  in  clog2(RAM_DEPTH)  word address within bank
- wr_data  in  RAM_WIDTH  write data
- wr_be  in  RAM_WIDTH/8  byte enables (present only with CONV_BRAM_BYTE_WE_EN)
- wr_done  in  1  writer marks current write bank complete
- wr_ready  out  1  current write bank is free
- wr_bank  out  clog2(NUM_BANKS)  index of current write bank
- rd_en  in  1  read strobe from current read bank
- rd_addr  in  clog2(RAM_DEPTH)  word address within bank
- rd_done  in  1  reader releases current read bank
- rd_ready  out  1  current read bank is full
- rd_bank  out  clog2(NUM_BANKS)  index of current read bank
- rd_data  out  RAM_WIDTH  read data
- rd_valid  out  1  rd_data holds a valid word this cycle
- full_cnt  out  clog2(NUM_BANKS+1)  number of full banks
- err_wr  out  1  sticky; write or wr_done rejected
- err_rd  out  1  sticky; read or rd_done rejected

## Operation
- Storage: NUM_BANKS*RAM_DEPTH words in one block-RAM array. Physical address = bank*RAM_DEPTH + addr. Contents are not reset.
- Per-bank state is a single full bit. The write pointer wb and read pointer rb are each a modulo-NUM_BANKS counter.
- wr_ready = !full[wb]. rd_ready = full[rb].
- Write is accepted when wr_en & wr_ready & wr_addr<RAM_DEPTH. Otherwise the write is dropped and err_wr is set.
- wr_done with wr_ready: full[wb]<=1, wb<=wb+1 (wrap NUM_BANKS-1 -> 0). wr_done without wr_ready: ignored, err_wr is set.
- Read is accepted when rd_en & rd_ready & rd_addr<RAM_DEPTH. Otherwise no rd_valid is produced and err_rd is set.
- rd_done with rd_ready: full[rb]<=0, rb<=rb+1 (wrap). rd_done without rd_ready: ignored, err_rd is set.
- A write accepted in the same cycle as wr_done lands in the old wb bank. A read accepted in the same cycle as rd_done reads the old rb bank.
- wr_done and rd_done in the same cycle both apply. full_cnt changes by (+1)+(-1)=0.
- If rb==wb and the bank is full, a same-cycle wr_done is rejected because wr_ready is low. The read release takes effect.
- rd_data holds its last value when rd_valid is low.
- err_wr and err_rd clear only on reset.

## Timing
- Reset (async assert, sync release): wb=0, rb=0, all full=0, full_cnt=0, wr_ready=1, rd_ready=0, rd_valid=0, rd_data=0, err_wr=0, err_rd=0.
- LOW_LATENCY: rd_data and rd_valid=1 on cycle N+1 for a read accepted on cycle N.
- HIGH_PERFORMANCE: rd_data and rd_valid=1 on cycle N+2. Back-to-back reads give back-to-back rd_valid.
- Reads are issued every cycle in either mode; no stall.
- The full bit, pointers, wr_ready, rd_ready and full_cnt update on the cycle after the done strobe.
- The earliest read of freshly written data is the cycle after the wr_done that completes its bank.
- Reset mid-operation: the in-flight read pipeline is flushed and rd_valid=0 immediately (async). All banks become empty.

## Configuration
- CONV_BRAM_BYTE_WE_EN defined: the wr_be port exists. An accepted write updates only bytes whose wr_be bit is 1; wr_be=0 still counts as an accepted write with no data change.
- Macro undefined: there is no wr_be port, and every accepted write updates the full word.

## Test plan
- Reset then write bank0 addr0..3 = 0x11..0x44 and pulse wr_done -> rd_ready=1, full_cnt=1, wr_bank=1. Reads addr0..3 return 0x11..0x44 with rd_valid at latency 1 (LOW_LATENCY) or 2 (HIGH_PERFORMANCE).
- NUM_BANKS=2: fill both banks -> wr_ready=0, full_cnt=2. A third wr_en and a wr_done -> dropped, err_wr=1, bank contents unchanged.
- rd_done on an empty buffer -> err_rd=1, rb stays 0. rd_en while rd_ready=0 -> no rd_valid.
- With one bank full and the writer on the other, pulse wr_done and rd_done in the same cycle -> full_cnt stays 1 and both pointers advance with wrap (1->0).
- With CONV_BRAM_BYTE_WE_EN: write 0xFFFF_FFFF_FFFF_FFFF, then write 0x0 with wr_be=8'h0F -> read returns 0xFFFF_FFFF_0000_0000.
- Assert rsta low during a stream of reads in HIGH_PERFORMANCE -> rd_valid=0 in the same cycle. After release, full_cnt=0 and rd_data=0.

Source files
------------

// File: rtl/conv_bram_pingpong.sv
`default_nettype none
// ============================================================================
// Module   : conv_bram_pingpong
// Purpose  : Multi-bank circular block-RAM buffer between the convolution
//            data loader (writer) and the conv compute array (reader). The
//            writer fills bank wb while the reader drains a completed bank rb.
//            Banks change hands through wr_done / rd_done handshakes.
// Ports    : clka/rsta            clock, async active-low reset
//            wr_en/wr_addr/wr_data write port into current write bank
//            wr_be                byte enables (CONV_BRAM_BYTE_WE_EN only)
//            wr_done/wr_ready/wr_bank  writer bank handshake and index
//            rd_en/rd_addr        read port from current read bank
//            rd_done/rd_ready/rd_bank  reader bank handshake and index
//            rd_data/rd_valid     read result, 1 or 2 cycle latency
//            full_cnt             number of full banks
//            err_wr/err_rd        sticky rejected-request flags
// Options  : `define CONV_BRAM_BYTE_WE_EN to add per-byte write enables.
// Revision : 1.0 - initial release
// ============================================================================
module conv_bram_pingpong #(
  parameter int    RAM_WIDTH       = 64,
  parameter int    RAM_DEPTH       = 512,
  parameter int    NUM_BANKS       = 2,
  parameter string RAM_PERFORMANCE = "LOW_LATENCY"
) (
  input  logic                             clka,
  input  logic                             rsta,
  input  logic                             wr_en,
  input  logic [$clog2(RAM_DEPTH)-1:0]     wr_addr,
  input  logic [RAM_WIDTH-1:0]             wr_data,
`ifdef CONV_BRAM_BYTE_WE_EN
  input  logic [RAM_WIDTH/8-1:0]           wr_be,
`endif
  input  logic                             wr_done,
  output logic                             wr_ready,
  output logic [$clog2(NUM_BANKS)-1:0]     wr_bank,
  input  logic                             rd_en,
  input  logic [$clog2(RAM_DEPTH)-1:0]     rd_addr,
  input  logic                             rd_done,
  output logic                             rd_ready,
  output logic [$clog2(NUM_BANKS)-1:0]     rd_bank,
  output logic [RAM_WIDTH-1:0]             rd_data,
  output logic                             rd_valid,
  output logic [$clog2(NUM_BANKS+1)-1:0]   full_cnt,
  output logic                             err_wr,
  output logic                             err_rd
);

  localparam int AW  = $clog2(RAM_DEPTH);
  localparam int BW  = $clog2(NUM_BANKS);
  localparam int PAW = $clog2(NUM_BANKS*RAM_DEPTH);
  localparam logic [BW-1:0] LAST_BANK = BW'(NUM_BANKS-1);
  localparam logic [AW:0]   DEPTH_LIM = (AW+1)'(RAM_DEPTH);

  logic [RAM_WIDTH-1:0] mem [NUM_BANKS*RAM_DEPTH];
  logic [NUM_BANKS-1:0] full;
  logic [BW-1:0]        wb;
  logic [BW-1:0]        rb;
  logic                 wr_addr_ok;
  logic                 rd_addr_ok;
  logic                 wr_acc;
  logic                 rd_acc;
  logic                 wr_done_acc;
  logic                 rd_done_acc;
  logic [PAW-1:0]       wr_phys;
  logic [PAW-1:0]       rd_phys;

  function automatic logic [BW-1:0] next_bank(input logic [BW-1:0] b);
    return (b == LAST_BANK) ? '0 : b + 1'b1;
  endfunction

  assign wr_ready    = ~full[wb];
  assign rd_ready    = full[rb];
  assign wr_bank     = wb;
  assign rd_bank     = rb;

  // Range check matters only when RAM_DEPTH is not a power of two.
  assign wr_addr_ok  = ({1'b0, wr_addr} < DEPTH_LIM);
  assign rd_addr_ok  = ({1'b0, rd_addr} < DEPTH_LIM);
  assign wr_acc      = wr_en & wr_ready & wr_addr_ok;
  assign rd_acc      = rd_en & rd_ready & rd_addr_ok;
  assign wr_done_acc = wr_done & wr_ready;
  assign rd_done_acc = rd_done & rd_ready;

  assign wr_phys = PAW'(wb) * PAW'(RAM_DEPTH) + PAW'(wr_addr);
  assign rd_phys = PAW'(rb) * PAW'(RAM_DEPTH) + PAW'(rd_addr);

  // An accepted wr_done needs full[wb]=0 and an accepted rd_done needs
  // full[rb]=1, so when both fire they always touch different banks.
  always_ff @(posedge clka or negedge rsta) begin
    if (!rsta) begin
      full     <= '0;
      wb       <= '0;
      rb       <= '0;
      full_cnt <= '0;
      err_wr   <= 1'b0;
      err_rd   <= 1'b0;
    end else begin
      if (wr_done_acc) begin
        full[wb] <= 1'b1;
        wb       <= next_bank(wb);
      end
      if (rd_done_acc) begin
        full[rb] <= 1'b0;
        rb       <= next_bank(rb);
      end
      if (wr_done_acc && !rd_done_acc) begin
        full_cnt <= full_cnt + 1'b1;
      end else if (!wr_done_acc && rd_done_acc) begin
        full_cnt <= full_cnt - 1'b1;
      end
      if ((wr_en && !wr_acc) || (wr_done && !wr_ready)) begin
        err_wr <= 1'b1;
      end
      if ((rd_en && !rd_acc) || (rd_done && !rd_ready)) begin
        err_rd <= 1'b1;
      end
    end
  end

  // Storage array, never reset. Reader and writer can never address the same
  // bank in one cycle, so no read/write collision handling is needed.
  always_ff @(posedge clka) begin
    if (wr_acc) begin
`ifdef CONV_BRAM_BYTE_WE_EN
      for (int i = 0; i < RAM_WIDTH/8; i++) begin
        if (wr_be[i]) begin
          mem[wr_phys][i*8 +: 8] <= wr_data[i*8 +: 8];
        end
      end
`else
      mem[wr_phys] <= wr_data;
`endif
    end
  end

  generate
    if (RAM_PERFORMANCE == "HIGH_PERFORMANCE") begin : g_high_perf
      logic [RAM_WIDTH-1:0] ram_q;
      logic                 ram_v;

      // RAM-internal read stage, then a resettable output register.
      always_ff @(posedge clka) begin
        if (rd_acc) begin
          ram_q <= mem[rd_phys];
        end
      end

      always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
          ram_v    <= 1'b0;
          rd_valid <= 1'b0;
          rd_data  <= '0;
        end else begin
          ram_v    <= rd_acc;
          rd_valid <= ram_v;
          if (ram_v) begin
            rd_data <= ram_q;
          end
        end
      end
    end else begin : g_low_lat
      always_ff @(posedge clka or negedge rsta) begin
        if (!rsta) begin
          rd_valid <= 1'b0;
          rd_data  <= '0;
        end else begin
          rd_valid <= rd_acc;
          if (rd_acc) begin
            rd_data <= mem[rd_phys];
          end
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_conv_bram_pingpong.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_bram_pingpong
// Purpose  : Self-checking bench for conv_bram_pingpong. Drives one
//            LOW_LATENCY and one HIGH_PERFORMANCE instance with identical
//            stimulus and compares both against a bank-level reference model.
// Options  : honours CONV_BRAM_BYTE_WE_EN (wr_be connected and modelled).
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_bram_pingpong;

  localparam int W  = 64;
  localparam int D  = 16;
  localparam int NB = 2;

  logic          clka = 1'b0;
  logic          rsta = 1'b1;
  logic          wr_en, wr_done, rd_en, rd_done;
  logic [3:0]    wr_addr, rd_addr;
  logic [W-1:0]  wr_data;
  logic [7:0]    wr_be;

  logic          wr_ready_ll, rd_ready_ll, rd_valid_ll, err_wr_ll, err_rd_ll;
  logic          wr_ready_hp, rd_ready_hp, rd_valid_hp, err_wr_hp, err_rd_hp;
  logic [0:0]    wr_bank_ll, rd_bank_ll, wr_bank_hp, rd_bank_hp;
  logic [1:0]    full_cnt_ll, full_cnt_hp;
  logic [W-1:0]  rd_data_ll, rd_data_hp;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clka = ~clka;

  conv_bram_pingpong #(.RAM_WIDTH(W), .RAM_DEPTH(D), .NUM_BANKS(NB),
                       .RAM_PERFORMANCE("LOW_LATENCY")) u_ll (
    .clka(clka), .rsta(rsta), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef CONV_BRAM_BYTE_WE_EN
    .wr_be(wr_be),
`endif
    .wr_done(wr_done), .wr_ready(wr_ready_ll), .wr_bank(wr_bank_ll),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_done(rd_done), .rd_ready(rd_ready_ll),
    .rd_bank(rd_bank_ll), .rd_data(rd_data_ll), .rd_valid(rd_valid_ll),
    .full_cnt(full_cnt_ll), .err_wr(err_wr_ll), .err_rd(err_rd_ll));

  conv_bram_pingpong #(.RAM_WIDTH(W), .RAM_DEPTH(D), .NUM_BANKS(NB),
                       .RAM_PERFORMANCE("HIGH_PERFORMANCE")) u_hp (
    .clka(clka), .rsta(rsta), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef CONV_BRAM_BYTE_WE_EN
    .wr_be(wr_be),
`endif
    .wr_done(wr_done), .wr_ready(wr_ready_hp), .wr_bank(wr_bank_hp),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_done(rd_done), .rd_ready(rd_ready_hp),
    .rd_bank(rd_bank_hp), .rd_data(rd_data_hp), .rd_valid(rd_valid_hp),
    .full_cnt(full_cnt_hp), .err_wr(err_wr_hp), .err_rd(err_rd_hp));

  // ---------------- reference model (bank/word level) ----------------
  logic [W-1:0] m_mem [NB][D];
  bit           m_full [NB];
  int           m_wb, m_rb;
  bit           m_err_wr, m_err_rd;
  // expected read results: each accepted read becomes visible after L cycles
  bit           ll_v, hp_v, hp_v1;
  logic [W-1:0] ll_d, hp_d, hp_d1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] be_eff();
`ifdef CONV_BRAM_BYTE_WE_EN
    return wr_be;
`else
    return (wr_be | 8'hFF);
`endif
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) m_full[b] = 1'b0;
    m_wb = 0; m_rb = 0; m_err_wr = 0; m_err_rd = 0;
    ll_v = 0; hp_v = 0; hp_v1 = 0;
    ll_d = '0; hp_d = '0; hp_d1 = '0;
  endtask

  task automatic model_edge();
    bit           wrdy, rrdy, racc;
    logic [W-1:0] rval, word;
    logic [7:0]   be;
    int           owb, orb;
    wrdy = !m_full[m_wb];
    rrdy = m_full[m_rb];
    owb  = m_wb;
    orb  = m_rb;
    racc = rd_en && rrdy;
    rval = racc ? m_mem[orb][rd_addr] : '0;
    if (wr_en && wrdy) begin
      word = m_mem[owb][wr_addr];
      be   = be_eff();
      for (int i = 0; i < 8; i++) if (be[i]) word[i*8 +: 8] = wr_data[i*8 +: 8];
      m_mem[owb][wr_addr] = word;
    end
    if ((wr_en && !wrdy) || (wr_done && !wrdy)) m_err_wr = 1;
    if ((rd_en && !rrdy) || (rd_done && !rrdy)) m_err_rd = 1;
    if (wr_done && wrdy) begin m_full[owb] = 1; m_wb = (owb + 1) % NB; end
    if (rd_done && rrdy) begin m_full[orb] = 0; m_rb = (orb + 1) % NB; end
    hp_v = hp_v1;
    if (hp_v1) hp_d = hp_d1;
    hp_v1 = racc;
    if (racc) hp_d1 = rval;
    ll_v = racc;
    if (racc) ll_d = rval;
  endtask

  task automatic compare_all();
    int fc = 0;
    for (int b = 0; b < NB; b++) fc += int'(m_full[b]);
    check("wr_ready_ll", 64'(wr_ready_ll), 64'(!m_full[m_wb]));
    check("wr_ready_hp", 64'(wr_ready_hp), 64'(!m_full[m_wb]));
    check("rd_ready_ll", 64'(rd_ready_ll), 64'(m_full[m_rb]));
    check("rd_ready_hp", 64'(rd_ready_hp), 64'(m_full[m_rb]));
    check("wr_bank_ll",  64'(wr_bank_ll),  64'(m_wb));
    check("wr_bank_hp",  64'(wr_bank_hp),  64'(m_wb));
    check("rd_bank_ll",  64'(rd_bank_ll),  64'(m_rb));
    check("rd_bank_hp",  64'(rd_bank_hp),  64'(m_rb));
    check("full_cnt_ll", 64'(full_cnt_ll), 64'(fc));
    check("full_cnt_hp", 64'(full_cnt_hp), 64'(fc));
    check("err_wr_ll",   64'(err_wr_ll),   64'(m_err_wr));
    check("err_wr_hp",   64'(err_wr_hp),   64'(m_err_wr));
    check("err_rd_ll",   64'(err_rd_ll),   64'(m_err_rd));
    check("err_rd_hp",   64'(err_rd_hp),   64'(m_err_rd));
    check("rd_valid_ll", 64'(rd_valid_ll), 64'(ll_v));
    check("rd_valid_hp", 64'(rd_valid_hp), 64'(hp_v));
    check("rd_data_ll",  rd_data_ll, ll_d);
    check("rd_data_hp",  rd_data_hp, hp_d);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_idle();
    wr_en = 0; wr_done = 0; rd_en = 0; rd_done = 0;
    wr_addr = '0; rd_addr = '0; wr_data = '0; wr_be = 8'hFF;
  endtask

  task automatic step();
    @(posedge clka);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    set_idle();
    rsta = 1'b0;
    model_reset();
    #1;
    check("rst_rd_valid_ll", 64'(rd_valid_ll), 64'(0));
    check("rst_rd_valid_hp", 64'(rd_valid_hp), 64'(0));
    repeat (2) @(posedge clka);
    #1;
    compare_all();
    rsta = 1'b1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [W-1:0] d, input logic [7:0] be, input bit done);
    set_idle();
    wr_en = 1; wr_addr = a; wr_data = d; wr_be = be; wr_done = done;
    step();
    set_idle();
  endtask

  task automatic pulse(input bit wd, input bit rdn);
    set_idle();
    wr_done = wd; rd_done = rdn;
    step();
    set_idle();
  endtask

  task automatic rd(input logic [3:0] a);
    set_idle();
    rd_en = 1; rd_addr = a;
    step();
    set_idle();
  endtask

  initial begin
    set_idle();
    #3;
    // reset state
    do_reset();
    check("reset_wr_ready", 64'(wr_ready_ll), 64'(1));
    check("reset_rd_data",  rd_data_hp, 64'(0));

    // fill bank 0, hand it over, read back
    for (int i = 0; i < 4; i++) wr(4'(i), 64'(8'h11 * (i + 1)), 8'hFF, 1'b0);
    pulse(1, 0);
    check("t1_rd_ready", 64'(rd_ready_ll), 64'(1));
    check("t1_full_cnt", 64'(full_cnt_hp), 64'(1));
    check("t1_wr_bank",  64'(wr_bank_ll), 64'(1));
    for (int i = 0; i < 4; i++) rd(4'(i));
    check("t1_last_ll", rd_data_ll, 64'h44);
    step();
    step();
    check("t1_last_hp", rd_data_hp, 64'h44);

    // fill both banks, then a rejected write and wr_done
    wr(4'd0, 64'hA5A5_5A5A_0000_FFFF, 8'hFF, 1'b1);
    check("t2_wr_ready", 64'(wr_ready_ll), 64'(0));
    check("t2_full_cnt", 64'(full_cnt_ll), 64'(2));
    wr(4'd0, 64'hDEAD_BEEF, 8'hFF, 1'b1);
    check("t2_err_wr", 64'(err_wr_hp), 64'(1));
    rd(4'd0);
    step();
    step();
    check("t2_unchanged", rd_data_hp, 64'h11);

    // rd_done / rd_en on empty buffer
    do_reset();
    pulse(0, 1);
    check("t3_err_rd", 64'(err_rd_ll), 64'(1));
    check("t3_rb",     64'(rd_bank_ll), 64'(0));
    rd(4'd2);
    step();
    check("t3_no_valid", 64'(rd_valid_hp), 64'(0));

    // simultaneous wr_done and rd_done with wrap
    do_reset();
    wr(4'd5, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1);
    pulse(1, 1);
    check("t4_full_cnt", 64'(full_cnt_ll), 64'(1));
    check("t4_wb_wrap",  64'(wr_bank_ll), 64'(0));
    check("t4_rb",       64'(rd_bank_hp), 64'(1));

    // byte enables: bank 0 is the write bank, bank 1 is full
    wr(4'd7, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0);
    wr(4'd7, 64'h0, 8'h0F, 1'b1);
    pulse(0, 1);
    rd(4'd7);
    step();
    step();
`ifdef CONV_BRAM_BYTE_WE_EN
    check("t5_byte_we", rd_data_hp, 64'hFFFF_FFFF_0000_0000);
`else
    check("t5_full_word", rd_data_hp, 64'h0);
`endif

    // randomized traffic
    do_reset();
    for (int n = 0; n < 800; n++) begin
      wr_en   = ($urandom % 2) == 0;
      wr_addr = 4'($urandom);
      wr_data = {$urandom, $urandom};
      wr_be   = 8'($urandom);
      wr_done = ($urandom % 12) == 0;
      rd_en   = ($urandom % 2) == 0;
      rd_addr = 4'($urandom);
      rd_done = ($urandom % 12) == 0;
      step();
    end
    set_idle();

    // reset in the middle of a high-performance read stream
    do_reset();
    for (int i = 0; i < D; i++) wr(4'(i), {$urandom, $urandom}, 8'hFF, i == D - 1);
    set_idle();
    for (int i = 0; i < 6; i++) begin
      rd_en = 1; rd_addr = 4'(i);
      step();
    end
    check("t6_streaming", 64'(rd_valid_hp), 64'(1));
    #2;
    do_reset();
    check("t6_full_cnt", 64'(full_cnt_hp), 64'(0));
    check("t6_rd_data",  rd_data_hp, 64'(0));
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
